// File: rtl/regfile_scanner_if.sv
// Word stream from the register-file scanner to its consumer.
// The master presents (addr, data, last) under valid; the slave accepts with ready.
interface regfile_scanner_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_scanner.sv
// Sequential read-out engine: walks registers 0..NUM_REGS-1 through one
// regfile read port and streams each (address, data) pair over valid/ready.
// Every register costs one READ cycle plus at least one SEND cycle.
module regfile_scanner #(
    parameter int NUM_REGS = 64,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [ADDR_W-1:0]   rdAddr,
    input  logic [DATA_W-1:0]   rdData,
    regfile_scanner_if.master   stream,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t              state_reg,     state_next;
    logic [ADDR_W-1:0]   index_reg,     index_next;
    logic [ADDR_W-1:0]   out_addr_reg,  out_addr_next;
    logic [DATA_W-1:0]   out_data_reg,  out_data_next;
    logic                out_valid_reg, out_valid_next;
    logic                done_reg,      done_next;

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            out_addr_reg  <= out_addr_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            done_reg      <= done_next;
        end
    end

    // Next-state logic. abort outranks both start and a consumer acceptance;
    // a word accepted on the abort edge is transferred but the scan ends
    // without a done pulse. The index never wraps: it returns to 0 only on
    // completion, abort or reset.
    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        out_addr_next  = out_addr_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next = READ;
                    index_next = '0;
                end
            end

            READ: begin
                if (abort) begin
                    state_next     = IDLE;
                    index_next     = '0;
                    out_valid_next = 1'b0;
                end else begin
                    // rdData is combinational for rdAddr=index; capture the
                    // live value, so writes to unread registers are visible.
                    out_data_next  = rdData;
                    out_addr_next  = index_reg;
                    out_valid_next = 1'b1;
                    state_next     = SEND;
                end
            end

            SEND: begin
                if (abort) begin
                    state_next     = IDLE;
                    index_next     = '0;
                    out_valid_next = 1'b0;
                end else if (stream.out_ready) begin
                    out_valid_next = 1'b0;
                    if (index_reg == LAST_IDX) begin
                        state_next = IDLE;
                        index_next = '0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = READ;
                        index_next = index_reg + ONE;
                    end
                end
            end

            default: begin
                state_next     = IDLE;
                index_next     = '0;
                out_valid_next = 1'b0;
            end
        endcase
    end

    // Read address is parked at 0 while idle; otherwise it tracks the index.
    always_comb begin
        rdAddr = (state_reg == IDLE) ? '0 : index_reg;
    end

    // Status and stream outputs come straight from registers.
    always_comb begin
        busy             = (state_reg != IDLE);
        done             = done_reg;
        stream.out_valid = out_valid_reg;
        stream.out_addr  = out_addr_reg;
        stream.out_data  = out_data_reg;
        stream.out_last  = out_valid_reg && (out_addr_reg == LAST_IDX);
    end

endmodule

// File: doc/regfile_scanner.md
# regfile_scanner

Sequential read-out engine for the 64 x 16 register file. On a start pulse it walks every register address through one regfile read port and streams each (address, data) pair to a downstream consumer, normally the VGA register-display text generator, over a valid/ready handshake. It is the reader counterpart to the datapath's regfile write port. It drives one read address and never writes the register file.

## Interface
Parameters:
- NUM_REGS, 64: number of registers scanned, addresses 0..NUM_REGS-1.
- ADDR_W, 6: register address width; NUM_REGS <= 2^ADDR_W.
- DATA_W, 16: register data width.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  begin a scan; sampled only in IDLE.
- abort  in  1  synchronous cancel of a scan in progress.
- rdAddr  out  ADDR_W  address to the regfile read port (rdAddr0 or rdAddr1).
- rdData  in  DATA_W  combinational read data returned for rdAddr.
- out_valid  out  1  out_addr/out_data/out_last hold a word for the consumer.
- out_ready  in  1  consumer accepts the word on this edge when out_valid=1.
- out_addr  out  ADDR_W  register index of the presented word.
- out_data  out  DATA_W  register contents captured for out_addr.
- out_last  out  1  presented word is index NUM_REGS-1.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- State machine: IDLE, READ, SEND.
- IDLE: busy=0, out_valid=0, rdAddr=0. start=1 moves to READ with index=0.
- READ: busy=1, rdAddr=index. At the next edge rdData is captured into out_data, index is captured into out_addr, out_valid is set, and the state moves to SEND.
- SEND: busy=1, out_valid=1. Outputs hold stable until out_ready=1.
  - On acceptance with index<NUM_REGS-1: index+1, go to READ, out_valid drops.
  - On acceptance with index=NUM_REGS-1: go to IDLE, done=1 for one cycle, index=0.
- out_last = out_valid & (out_addr==NUM_REGS-1).
- abort=1 in READ or SEND: next state is IDLE, out_valid=0, index=0, no done pulse.
  - abort has priority over out_ready and over the last-word acceptance.
  - If valid&ready coincides with abort, the consumer still counts that word as transferred, but the scan is incomplete.
- start while busy: ignored. abort in IDLE: no effect. start and abort together in IDLE: abort wins, stay IDLE.
- There is no snapshot coherence. Each word reflects the register contents in its own READ cycle, so regfile writes during a scan show up for not-yet-read addresses.
- Index arithmetic is ADDR_W bits wide. It never wraps past NUM_REGS-1; it returns to 0 only via completion, abort, or reset.

## Timing
- Reset (asynchronous, any state): state=IDLE, index=0, rdAddr=0, out_valid=0, out_addr=0, out_data=0, out_last=0, busy=0, done=0.
- Reset mid-scan discards the scan; no done pulse.
- start sampled at edge E0: READ during the cycle after E0, first out_valid after E1.
- Each register costs exactly 2 cycles plus the number of out_ready-low cycles in SEND.
- Full scan with out_ready held high: the last acceptance occurs at edge E(2*NUM_REGS) = E128. done is high in the following cycle only, and busy falls in that same cycle.
- New start is accepted in the cycle done is high (state is IDLE). The next scan has a 1-cycle gap.
- out_data for a word equals rdData as sampled at the edge ending its READ cycle.

## Test plan
- Preload the regfile with reg[i]=0x1100+i, start pulse, out_ready=1 -> 64 words with out_addr=i and out_data=0x1100+i. out_last only on i=63. done pulses once, 128 cycles after the start edge.
- Backpressure: out_ready low 5 cycles on word 10 -> out_valid, out_addr=10 and out_data held stable through the stall. Exactly one transfer of word 10 and no skipped index.
- Write reg[40]=0xBEEF while the scan is at index 20 -> word 40 reads 0xBEEF. Write reg[5]=0x0000 at the same time -> word 5 keeps its old value.
- abort asserted in SEND at index 30 -> IDLE next cycle, out_valid=0, busy=0, no done. A subsequent start restarts at index 0.
- start re-pulsed while busy at index 12 -> ignored, the scan continues at 13. rst asserted asynchronously mid-scan -> all outputs 0 immediately, no done.
- Reset release with start=1 and abort=1 on the same edge -> remains IDLE. Next start alone -> rdAddr=0 in the following cycle.
